// File: rtl/qspi_flash_emu.sv
// qspi_flash_emu: oversampled serial-flash read emulator (cmd, addr, mode, dummy, streaming data)
module qspi_flash_emu #(
  parameter int         LANES        = 4,
  parameter int         ADDR_BITS    = 24,
  parameter int         DUMMY_CYCLES = 4,
  parameter int         MODE_BYTE    = 1,
  parameter logic [7:0] CMD_READ     = 8'h0B,
  parameter int         MEM_BYTES    = 4096,
  parameter             INIT_FILE    = ""
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             select,
  input  logic [LANES-1:0] cmd_addr_in,
  output logic [LANES-1:0] data_out,
  output logic             busy,
  output logic             cont_mode,
  output logic             cmd_error
);
  if (!(LANES == 1 || LANES == 2 || LANES == 4) || (ADDR_BITS % LANES) != 0) begin : g_bad_params
    $fatal(1, "qspi_flash_emu: illegal LANES/ADDR_BITS combination");
  end
  localparam int AW  = $clog2(MEM_BYTES);
  localparam int SW0 = ADDR_BITS > 8 ? ADDR_BITS : 8;
  localparam int SW  = SW0 > AW ? SW0 : AW;
  localparam int CPB = 8 / LANES;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE} state_t;
  localparam state_t AFTER_MODE = DUMMY_CYCLES != 0 ? DUMMY : DATA;
  logic [7:0] mem [MEM_BYTES];
  logic             sclk_q, sel_q;
  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d, cnt_n, lim, byte_sh;
  logic [SW-1:0]    sh_q, sh_d, sh_n;
  logic [AW-1:0]    addr_q, addr_d;
  logic [2:0]       idx_q, idx_d;
  logic [LANES-1:0] data_out_q, data_out_d;
  logic             cont_q, cont_d, err_q, err_d;
  logic             rise, fall, sel_fall, sel_rise, done;
  always_ff @(posedge clk) begin
    sclk_q <= sclk;
    sel_q  <= select;
  end
  assign rise     = sclk & ~sclk_q & ~select;
  assign fall     = ~sclk & sclk_q & ~select;
  assign sel_fall = ~select & sel_q;
  assign sel_rise = select & ~sel_q;
  always_comb begin
    lim = state_q == ADDR ? 8'(ADDR_BITS / LANES) : state_q == DUMMY ? 8'(DUMMY_CYCLES) : 8'(CPB);
    sh_n = {sh_q[SW-LANES-1:0], cmd_addr_in};
    cnt_n = cnt_q + 8'd1;
    done = rise && cnt_n == lim;
    byte_sh = mem[addr_q] << (LANES * idx_q);
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    addr_d = addr_q;
    idx_d = idx_q;
    cont_d = cont_q;
    err_d = err_q;
    data_out_d = state_q == DATA ? data_out_q : '0;
    if (sel_rise) begin
      state_d = IDLE;
      data_out_d = '0;
    end else if (sel_fall) begin
      state_d = cont_q ? ADDR : CMD;
      cnt_d = '0;
      sh_d = '0;
      err_d = 1'b0;
    end else if (state_q inside {CMD, ADDR, MODE, DUMMY} && rise) begin
      cnt_d = cnt_n;
      sh_d = sh_n;
      if (done) begin
        cnt_d = '0;
        sh_d = '0;
        idx_d = '0;
        case (state_q)
          CMD: begin
            state_d = sh_n[7:0] == CMD_READ ? ADDR : IGNORE;
            err_d = sh_n[7:0] != CMD_READ;
          end
          ADDR: begin
            addr_d = sh_n[AW-1:0];
            state_d = MODE_BYTE != 0 ? MODE : AFTER_MODE;
          end
          MODE: begin
            cont_d = sh_n[5:4] == 2'b10;
            state_d = AFTER_MODE;
          end
          default: state_d = DATA;
        endcase
      end
    end else if (state_q == DATA && fall) begin
      data_out_d = byte_sh[7 -: LANES];
      idx_d = idx_q == 3'(CPB - 1) ? 3'd0 : idx_q + 3'd1;
      addr_d = idx_q == 3'(CPB - 1) ? addr_q + AW'(1) : addr_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      data_out_q <= '0;
      cont_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
      cont_q     <= cont_d;
      err_q      <= err_d;
    end
  end
  assign data_out  = data_out_q;
  assign busy      = state_q != IDLE;
  assign cont_mode = cont_q;
  assign cmd_error = err_q;
endmodule

// File: tb/tb_qspi_flash_emu.sv
// tb_qspi_flash_emu: vector table, corner sequences and random reads against a byte-level model
module tb_qspi_flash_emu;
  logic       clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, select = 1'b1;
  logic [3:0] cmd_addr_in = '0;
  logic [3:0] data_out;
  logic       busy, cont_mode, cmd_error;
  qspi_flash_emu dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .select(select), .cmd_addr_in(cmd_addr_in),
    .data_out(data_out), .busy(busy), .cont_mode(cont_mode), .cmd_error(cmd_error)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        do_cmd;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [7:0]  mode;
    logic        exp_cont;
    logic        exp_err;
    logic        use_word;
    logic [15:0] word;
  } vec_t;
  vec_t       vt [7];
  logic [7:0] mm [4096];
  logic [3:0] got [32];
  int         n_chk = 0, n_pass = 0;
  logic       cont_m = 1'b0;
  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [3:0] exp_nib(input logic [23:0] a, input int k);
    logic [7:0] b;
    b = mm[(int'(a) + k / 2) % 4096];
    return (k % 2 == 0) ? b[7:4] : b[3:0];
  endfunction
  task automatic shift_cycle(input logic [3:0] v, output logic [3:0] d);
    cmd_addr_in = v;
    clk_n(1);
    sclk = 1'b1;
    clk_n(4);
    sclk = 1'b0;
    clk_n(4);
    d = data_out;
  endtask
  task automatic run_txn(input logic do_cmd, input logic [7:0] cmd, input logic [23:0] addr,
                         input logic [7:0] mode, input int nnib);
    logic [3:0] d;
    select = 1'b0;
    clk_n(3);
    if (do_cmd) for (int i = 0; i < 2; i++) shift_cycle(4'(cmd >> (4 * (1 - i))), d);
    for (int i = 0; i < 6; i++) shift_cycle(4'(addr >> (4 * (5 - i))), d);
    for (int i = 0; i < 2; i++) shift_cycle(4'(mode >> (4 * (1 - i))), d);
    for (int i = 0; i < 4; i++) shift_cycle(4'd0, d);
    got[0] = d;
    for (int i = 1; i < nnib; i++) begin
      shift_cycle(4'd0, d);
      got[i] = d;
    end
  endtask
  task automatic end_txn();
    select = 1'b1;
    clk_n(3);
  endtask
  initial begin
    logic [3:0]  d;
    logic [15:0] w, ew;
    logic [7:0]  c, m;
    logic [23:0] a;
    logic        dc, bad;
    int          nn;
    vt[0] = '{1'b1, 8'h0B, 24'h000010, 8'h00, 1'b0, 1'b0, 1'b1, 16'hA53C};
    vt[1] = '{1'b1, 8'h0B, 24'h000FFF, 8'h00, 1'b0, 1'b0, 1'b1, 16'h1234};
    vt[2] = '{1'b1, 8'h0B, 24'h000100, 8'hA0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vt[3] = '{1'b0, 8'h00, 24'h000020, 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0000};
    vt[4] = '{1'b1, 8'h0B, 24'h000030, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000};
    vt[5] = '{1'b1, 8'h9F, 24'h000040, 8'h00, 1'b0, 1'b1, 1'b1, 16'h0000};
    vt[6] = '{1'b1, 8'h0B, 24'h000050, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000};
    for (int i = 0; i < 4096; i++) mm[i] = 8'($urandom);
    mm[16'h010] = 8'hA5;
    mm[16'h011] = 8'h3C;
    mm[16'hFFF] = 8'h12;
    mm[16'h000] = 8'h34;
    for (int i = 0; i < 4096; i++) dut.mem[i] = mm[i];
    clk_n(3);
    check("reset data_out", 32'(data_out), 0);
    check("reset busy", 32'(busy), 0);
    check("reset cont_mode", 32'(cont_mode), 0);
    check("reset cmd_error", 32'(cmd_error), 0);
    rst_n = 1'b1;
    clk_n(2);
    check("idle busy", 32'(busy), 0);
    for (int r = 0; r < 7; r++) begin
      run_txn(vt[r].do_cmd, vt[r].cmd, vt[r].addr, vt[r].mode, 4);
      w = {got[0], got[1], got[2], got[3]};
      ew = vt[r].exp_err ? 16'h0 : {exp_nib(vt[r].addr, 0), exp_nib(vt[r].addr, 1),
                                    exp_nib(vt[r].addr, 2), exp_nib(vt[r].addr, 3)};
      if (vt[r].use_word) ew = vt[r].word;
      check($sformatf("vec%0d data", r), 32'(w), 32'(ew));
      check($sformatf("vec%0d cont_mode", r), 32'(cont_mode), 32'(vt[r].exp_cont));
      check($sformatf("vec%0d cmd_error", r), 32'(cmd_error), 32'(vt[r].exp_err));
      check($sformatf("vec%0d busy", r), 32'(busy), 1);
      end_txn();
      check($sformatf("vec%0d idle busy", r), 32'(busy), 0);
      check($sformatf("vec%0d idle data_out", r), 32'(data_out), 0);
      if (r == 5) begin
        check("cmd_error sticky", 32'(cmd_error), 1);
        select = 1'b0;
        clk_n(3);
        check("cmd_error clear on select", 32'(cmd_error), 0);
        end_txn();
      end
    end
    select = 1'b0;
    clk_n(3);
    for (int i = 0; i < 2; i++) shift_cycle(4'(8'h0B >> (4 * (1 - i))), d);
    for (int i = 0; i < 3; i++) shift_cycle(4'h0, d);
    check("abort busy before", 32'(busy), 1);
    select = 1'b1;
    clk_n(2);
    check("abort busy within 2 clk", 32'(busy), 0);
    clk_n(1);
    run_txn(1'b1, 8'h0B, 24'h000234, 8'h00, 4);
    w = {got[0], got[1], got[2], got[3]};
    check("after abort data", 32'(w),
          32'({exp_nib(24'h234, 0), exp_nib(24'h234, 1), exp_nib(24'h234, 2), exp_nib(24'h234, 3)}));
    end_txn();
    run_txn(1'b1, 8'h0B, 24'h000200, 8'hA0, 3);
    check("pre-reset cont_mode", 32'(cont_mode), 1);
    check("pre-reset data", 32'({got[0], got[1], got[2]}),
          32'({exp_nib(24'h200, 0), exp_nib(24'h200, 1), exp_nib(24'h200, 2)}));
    rst_n = 1'b0;
    clk_n(1);
    rst_n = 1'b1;
    check("mid reset data_out", 32'(data_out), 0);
    check("mid reset busy", 32'(busy), 0);
    check("mid reset cont_mode", 32'(cont_mode), 0);
    end_txn();
    run_txn(1'b1, 8'h0B, 24'h000300, 8'h00, 4);
    w = {got[0], got[1], got[2], got[3]};
    check("after reset data", 32'(w),
          32'({exp_nib(24'h300, 0), exp_nib(24'h300, 1), exp_nib(24'h300, 2), exp_nib(24'h300, 3)}));
    end_txn();
    cont_m = 1'b0;
    for (int t = 0; t < 20; t++) begin
      dc = !cont_m;
      bad = dc && ($urandom_range(0, 4) == 0);
      c = bad ? 8'h9F ^ 8'($urandom_range(0, 15) << 4) : 8'h0B;
      a = 24'($urandom);
      m = ($urandom_range(0, 1) == 0) ? (8'h20 | 8'($urandom_range(0, 15)) | 8'($urandom_range(0, 3) << 6))
                                      : 8'($urandom);
      nn = $urandom_range(1, 16);
      run_txn(dc, c, a, m, nn);
      if (!bad) cont_m = (m[5:4] == 2'b10);
      for (int k = 0; k < nn; k++)
        check($sformatf("rnd%0d nib%0d", t, k), 32'(got[k]), bad ? 0 : 32'(exp_nib(a, k)));
      check($sformatf("rnd%0d cmd_error", t), 32'(cmd_error), 32'(bad));
      check($sformatf("rnd%0d cont_mode", t), 32'(cont_mode), 32'(cont_m));
      end_txn();
      check($sformatf("rnd%0d idle", t), 32'({busy, data_out}), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
